// File: rtl/iq_upconverter_if.sv
// ----------------------------------------------------------------------------
// iq_upconverter_if
//   Sample bus between the TX baseband chain and the I/Q upconverter.
//   Ports (signals):
//     phase_inc   NCO tuning word, unsigned, sampled with in_valid
//     phase_load  synchronous clear of the NCO phase accumulator
//     i_in, q_in  signed baseband samples
//     in_valid    sample strobe, no backpressure
//     out_data    signed mixed output sample
//     out_valid   out_data strobe
//   Modports: master drives samples and receives the mixed output,
//             slave is the upconverter side.
// ----------------------------------------------------------------------------
interface iq_upconverter_if #(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned PHASE_WIDTH = 32
);
    logic [PHASE_WIDTH-1:0]   phase_inc;
    logic                     phase_load;
    logic signed [WIDTH-1:0]  i_in;
    logic signed [WIDTH-1:0]  q_in;
    logic                     in_valid;
    logic signed [WIDTH-1:0]  out_data;
    logic                     out_valid;

    modport master (
        output phase_inc, phase_load, i_in, q_in, in_valid,
        input  out_data, out_valid
    );

    modport slave (
        input  phase_inc, phase_load, i_in, q_in, in_valid,
        output out_data, out_valid
    );
endinterface

// File: rtl/iq_upconverter.sv
// ----------------------------------------------------------------------------
// iq_upconverter
//   Mixes baseband I/Q onto an NCO carrier: out = I*cos(ph) - Q*sin(ph).
//   NCO = phase accumulator + quarter-wave sine ROM. Fixed 4-clock latency
//   from in_valid to out_valid; gaps in in_valid reappear in out_valid.
//   Ports:
//     clock         rising-edge clock
//     clock_sreset  asynchronous reset, active-high
//     bus           iq_upconverter_if.slave (samples in, mixed sample out)
//   Build option:
//     IQ_UPCONV_SAT_EN  defined: output clamped to the signed WIDTH range,
//                       undefined: output wraps (low WIDTH bits kept).
// ----------------------------------------------------------------------------
module iq_upconverter #(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned LUT_AW      = 10
) (
    input  logic              clock,
    input  logic              clock_sreset,
    iq_upconverter_if.slave   bus
);
    localparam int unsigned QAW    = LUT_AW - 2;
    localparam int unsigned QN     = 1 << QAW;
    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned DW     = 2 * WIDTH + 1;
    localparam int          PEAK_I = (1 << (WIDTH - 1)) - 1;
    localparam logic signed [WIDTH-1:0] PEAK = WIDTH'(PEAK_I);
`ifdef IQ_UPCONV_SAT_EN
    localparam logic signed [DW-1:0] SAT_HI = DW'(PEAK_I);
    localparam logic signed [DW-1:0] SAT_LO = DW'(-PEAK_I - 1);
`endif

    // Quarter-wave sine table, built at elaboration: entry k = round(PEAK*sin(2*pi*k/2^LUT_AW))
    logic [WIDTH-1:0] rom [QN];
    for (genvar k = 0; k < QN; k++) begin : g_rom
        localparam real ANG = 2.0 * 3.14159265358979323846 * real'(k) / real'(1 << LUT_AW);
        localparam int  VAL = $rtoi(real'(PEAK_I) * $sin(ANG) + 0.5);
        assign rom[k] = WIDTH'(VAL);
    end

    // Full-circle sine from the quarter table; odd quadrants mirror, upper half negates.
    // The mirrored address for k=0 would be QN, outside the table: that is the exact peak.
    function automatic logic signed [WIDTH-1:0] sine_of(input logic [1:0] quad,
                                                          input logic [QAW-1:0] k);
        logic [QAW-1:0]          mk;
        logic signed [WIDTH-1:0] mag;
        mk = '0 - k;
        if (quad[0]) begin
            mag = (k == '0) ? PEAK : $signed(rom[mk]);
        end else begin
            mag = $signed(rom[k]);
        end
        return quad[1] ? -mag : mag;
    endfunction

    logic [PHASE_WIDTH-1:0]  acc_q,   acc_d;
    logic [3:0]              vld_q,   vld_d;
    logic signed [WIDTH-1:0] i1_q,    i1_d,   q1_q,   q1_d;
    logic [QAW-1:0]          k1_q,    k1_d;
    logic [1:0]              quad1_q, quad1_d;
    logic signed [WIDTH-1:0] i2_q,    i2_d,   q2_q,   q2_d;
    logic signed [WIDTH-1:0] sin2_q,  sin2_d, cos2_q, cos2_d;
    logic signed [PW-1:0]    pi3_q,   pi3_d,  pq3_q,  pq3_d;
    logic signed [WIDTH-1:0] out_q,   out_d;

    logic [PHASE_WIDTH-1:0]  phase_c;
    logic [LUT_AW-1:0]       idx_c;
    logic signed [DW-1:0]    diff_c;
`ifdef IQ_UPCONV_SAT_EN
    logic signed [DW-1:0]    shift_c;
`endif

    // Next-state logic for NCO and all pipeline stages
    always_comb begin
        acc_d   = acc_q;
        vld_d   = {vld_q[2:0], bus.in_valid};
        i1_d    = i1_q;
        q1_d    = q1_q;
        k1_d    = k1_q;
        quad1_d = quad1_q;
        i2_d    = i2_q;
        q2_d    = q2_q;
        sin2_d  = sin2_q;
        cos2_d  = cos2_q;
        pi3_d   = pi3_q;
        pq3_d   = pq3_q;
        out_d   = out_q;

        // A load coinciding with a sample makes that sample use phase 0
        phase_c = bus.phase_load ? '0 : acc_q;
        idx_c   = phase_c[PHASE_WIDTH-1 -: LUT_AW];

        if (bus.in_valid) begin
            acc_d = phase_c + bus.phase_inc;
        end else if (bus.phase_load) begin
            acc_d = '0;
        end

        // S1: capture samples and phase address
        if (bus.in_valid) begin
            i1_d    = bus.i_in;
            q1_d    = bus.q_in;
            k1_d    = idx_c[QAW-1:0];
            quad1_d = idx_c[LUT_AW-1 -: 2];
        end

        // S2: ROM read; cos is sin one quadrant ahead
        if (vld_q[0]) begin
            i2_d   = i1_q;
            q2_d   = q1_q;
            sin2_d = sine_of(quad1_q, k1_q);
            cos2_d = sine_of(quad1_q + 2'd1, k1_q);
        end

        // S3: products
        if (vld_q[1]) begin
            pi3_d = PW'(i2_q) * PW'(cos2_q);
            pq3_d = PW'(q2_q) * PW'(sin2_q);
        end

        // S4: difference, floor-shift back to sample scale, reduce
        diff_c = DW'(pi3_q) - DW'(pq3_q);
`ifdef IQ_UPCONV_SAT_EN
        shift_c = diff_c >>> (WIDTH - 1);
        if (shift_c > SAT_HI) begin
            shift_c = SAT_HI;
        end else if (shift_c < SAT_LO) begin
            shift_c = SAT_LO;
        end
        if (vld_q[2]) begin
            out_d = WIDTH'(shift_c);
        end
`else
        if (vld_q[2]) begin
            out_d = WIDTH'(diff_c >>> (WIDTH - 1));
        end
`endif
    end

    // State registers
    always_ff @(posedge clock or posedge clock_sreset) begin
        if (clock_sreset) begin
            acc_q   <= '0;
            vld_q   <= '0;
            i1_q    <= '0;
            q1_q    <= '0;
            k1_q    <= '0;
            quad1_q <= '0;
            i2_q    <= '0;
            q2_q    <= '0;
            sin2_q  <= '0;
            cos2_q  <= '0;
            pi3_q   <= '0;
            pq3_q   <= '0;
            out_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            vld_q   <= vld_d;
            i1_q    <= i1_d;
            q1_q    <= q1_d;
            k1_q    <= k1_d;
            quad1_q <= quad1_d;
            i2_q    <= i2_d;
            q2_q    <= q2_d;
            sin2_q  <= sin2_d;
            cos2_q  <= cos2_d;
            pi3_q   <= pi3_d;
            pq3_q   <= pq3_d;
            out_q   <= out_d;
        end
    end

    assign bus.out_data  = out_q;
    assign bus.out_valid = vld_q[3];

endmodule

// File: tb/tb_iq_upconverter.sv
// ----------------------------------------------------------------------------
// tb_iq_upconverter
//   Drives directed and random sample streams into iq_upconverter and compares
//   every cycle's out_valid/out_data against a floating-point mixer model
//   delayed by the 4-clock latency. Honours IQ_UPCONV_SAT_EN like the design.
// ----------------------------------------------------------------------------
module tb_iq_upconverter;
    localparam int unsigned WIDTH       = 12;
    localparam int unsigned PHASE_WIDTH = 32;
    localparam int unsigned LUT_AW      = 10;
    localparam int          PEAK        = 2047;
    localparam real         TWO_PI      = 2.0 * 3.14159265358979323846;

    logic clock;
    logic clock_sreset;

    iq_upconverter_if #(.WIDTH(WIDTH), .PHASE_WIDTH(PHASE_WIDTH)) bus ();

    iq_upconverter #(
        .WIDTH       (WIDTH),
        .PHASE_WIDTH (PHASE_WIDTH),
        .LUT_AW      (LUT_AW)
    ) dut (
        .clock        (clock),
        .clock_sreset (clock_sreset),
        .bus          (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit v;
        int d;
    } exp_t;

    exp_t        pipe[$];
    logic [31:0] acc;
    int          held;
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Rounded carrier amplitude at a full-circle table position
    function automatic int sinv(input int idx);
        real x;
        x = real'(PEAK) * $sin(TWO_PI * real'(idx % 1024) / 1024.0);
        if (x >= 0.0) return int'($floor(x + 0.5));
        return -int'($floor(-x + 0.5));
    endfunction

    // Mixed output for one sample at phase ph
    function automatic int mix(input logic [31:0] ph, input int i, input int q);
        int     idx;
        longint d;
        longint sh;
        idx = int'(ph >> 22);
        d   = longint'(i) * longint'(sinv(idx + 256)) - longint'(q) * longint'(sinv(idx));
        sh  = d >>> 11;
`ifdef IQ_UPCONV_SAT_EN
        if (sh > 2047)  sh = 2047;
        if (sh < -2048) sh = -2048;
        return int'(sh);
`else
        sh = sh & 64'hFFF;
        if (sh >= 2048) sh = sh - 4096;
        return int'(sh);
`endif
    endfunction

    task automatic model_reset();
        exp_t e;
        e.v  = 1'b0;
        e.d  = 0;
        pipe.delete();
        for (int k = 0; k < 3; k++) pipe.push_back(e);
        acc  = '0;
        held = 0;
    endtask

    // One clock: drive inputs, advance model, check what comes out after the edge
    task automatic cycle(input bit v, input bit ld, input logic [31:0] inc,
                         input int i, input int q);
        exp_t        e;
        logic [31:0] ph;
        bus.in_valid   = v;
        bus.phase_load = ld;
        bus.phase_inc  = inc;
        bus.i_in       = 12'(i);
        bus.q_in       = 12'(q);
        e.v = v;
        e.d = 0;
        if (v) begin
            ph  = ld ? 32'd0 : acc;
            e.d = mix(ph, i, q);
            acc = ph + inc;
        end else if (ld) begin
            acc = '0;
        end
        pipe.push_back(e);
        @(posedge clock);
        #1;
        e = pipe.pop_front();
        check("out_valid", longint'(bus.out_valid), longint'(e.v));
        if (e.v) held = e.d;
        check("out_data", longint'(bus.out_data), longint'(held));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 32'd0, 0, 0);
    endtask

    initial begin
        bit bv;
        bit bl;
        n_checks = 0;
        n_pass   = 0;
        clock_sreset   = 1'b1;
        bus.in_valid   = 1'b0;
        bus.phase_load = 1'b0;
        bus.phase_inc  = '0;
        bus.i_in       = '0;
        bus.q_in       = '0;
        model_reset();

        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_data", longint'(bus.out_data), 0);
        clock_sreset = 1'b0;
        idle(2);

        // Constant carrier phase 0: 1000 -> 999, valid after 4 clocks
        cycle(1'b1, 1'b1, 32'd0, 1000, 0);
        for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 32'd0, 1000, 0);
        idle(5);

        // Quarter-turn steps on Q: 0, -1000, 0, 999
        cycle(1'b1, 1'b1, 32'h4000_0000, 0, 1000);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'h4000_0000, 0, 1000);
        idle(5);

        // 45 degree overflow case: -1203 wrapped, 2047 clamped
        cycle(1'b1, 1'b1, 32'h2000_0000, 2047, -2048);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'h2000_0000, 2047, -2048);
        idle(5);

        // Valid gaps freeze the accumulator: pattern 1,0,0,1,1,0
        cycle(1'b1, 1'b1, 32'h4000_0000, 1000, 500);
        cycle(1'b0, 1'b0, 32'h4000_0000, 1000, 500);
        cycle(1'b0, 1'b0, 32'h4000_0000, 1000, 500);
        cycle(1'b1, 1'b0, 32'h4000_0000, 1000, 500);
        cycle(1'b1, 1'b0, 32'h4000_0000, 1000, 500);
        cycle(1'b0, 1'b0, 32'h4000_0000, 1000, 500);
        idle(5);

        // Load together with the third sample
        cycle(1'b1, 1'b0, 32'h4000_0000, -700, 1200);
        cycle(1'b1, 1'b0, 32'h4000_0000, -700, 1200);
        cycle(1'b1, 1'b1, 32'h4000_0000, -700, 1200);
        cycle(1'b1, 1'b0, 32'h4000_0000, -700, 1200);
        idle(5);

        // Reset mid-stream: outputs clear immediately, in-flight samples dropped
        cycle(1'b1, 1'b1, 32'h1234_5678, 1500, -900);
        cycle(1'b1, 1'b0, 32'h1234_5678, 1500, -900);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'h1234_5678, -1500, 900);
        #2;
        clock_sreset = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("midrst_out_valid", longint'(bus.out_valid), 0);
        check("midrst_out_data", longint'(bus.out_data), 0);
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        clock_sreset = 1'b0;
        idle(6);

        // Randomised stream with random gaps, loads and tuning words
        for (int n = 0; n < 600; n++) begin
            bv = ($urandom_range(0, 9) < 7);
            bl = ($urandom_range(0, 19) == 0);
            cycle(bv, bl, 32'($urandom),
                  int'($urandom_range(0, 4095)) - 2048,
                  int'($urandom_range(0, 4095)) - 2048);
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
